// File: rtl/pc_seq_ctrl_pkg.sv
// Shared configuration for the PC sequencing controller: default
// parameters, FSM state encoding and the instruction step size.
package pc_seq_ctrl_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] BOOT_ADDR_DEF = 32'h0000_0000;
    localparam int          RAM_DEPTH_DEF = 4096;
    localparam int          INSN_BYTES    = 4;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Fetch-side bus: the PC register handshake plus the instruction RAM
// request/ack. The controller is the master of this bundle.
interface pc_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_addr;
    logic            pc_write_en;
    logic [XLEN-1:0] pc_write_addr;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;

    modport master (
        input  pc_addr,
        input  imem_ack,
        output pc_write_en,
        output pc_write_addr,
        output imem_req,
        output imem_addr
    );

    modport slave (
        output pc_addr,
        output imem_ack,
        input  pc_write_en,
        input  pc_write_addr,
        input  imem_req,
        input  imem_addr
    );
endinterface

// File: rtl/pc_seq_ctrl_redirect_arb.sv
// Redirect priority select (trap > branch > jump) and the legality check
// applied to whatever address is about to be written into the PC.
// Trap vectors are trusted and bypass the check.
module pc_redirect_arb #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] BOOT_ADDR = '0,
    parameter int              RAM_DEPTH = 4096
) (
    input  logic            trap_req_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            jmp_valid_i,
    input  logic [XLEN-1:0] jmp_target_i,
    output logic            redir_valid_o,
    output logic            redir_is_trap_o,
    output logic [XLEN-1:0] redir_target_o,
    input  logic [XLEN-1:0] cand_addr_i,
    input  logic            cand_exempt_i,
    input  logic            cand_wrap_i,
    output logic [XLEN-1:0] final_addr_o,
    output logic            fault_o
);

    localparam logic [XLEN:0] DEPTH_W = (XLEN+1)'(RAM_DEPTH);

    logic [XLEN-1:0] offset;
    logic            illegal;

    // Pick the single winning redirect source in fixed priority order.
    always_comb begin
        redir_valid_o   = 1'b0;
        redir_is_trap_o = 1'b0;
        redir_target_o  = '0;
        if (trap_req_i) begin
            redir_valid_o   = 1'b1;
            redir_is_trap_o = 1'b1;
            redir_target_o  = trap_vec_i;
        end else if (br_taken_i) begin
            redir_valid_o  = 1'b1;
            redir_target_o = br_target_i;
        end else if (jmp_valid_i) begin
            redir_valid_o  = 1'b1;
            redir_target_o = jmp_target_i;
        end
    end

    // Offset from the RAM base: targets below the base wrap to a huge
    // offset, so a single unsigned compare covers both ends of the window.
    always_comb begin
        offset       = cand_addr_i - BOOT_ADDR;
        illegal      = cand_wrap_i
                     || ({1'b0, offset} >= DEPTH_W)
                     || (cand_addr_i[1:0] != 2'b00);
        fault_o      = !cand_exempt_i && illegal;
        final_addr_o = fault_o ? trap_vec_i : cand_addr_i;
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: issues instruction fetches, advances the PC on
// completion, and applies trap/branch/jump redirects. A redirect that
// arrives while a fetch is in flight is parked in pend_addr until the RAM
// acknowledges, so the bus never sees a request withdrawn mid-flight.
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] BOOT_ADDR = XLEN'(BOOT_ADDR_DEF),
    parameter int              RAM_DEPTH = RAM_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_seq_ctrl_if.master        bus,
    input  logic                 stall_i,
    input  logic                 trap_req_i,
    input  logic [XLEN-1:0]      trap_vec_i,
    input  logic                 br_taken_i,
    input  logic [XLEN-1:0]      br_target_i,
    input  logic                 jmp_valid_i,
    input  logic [XLEN-1:0]      jmp_target_i,
    output logic                 if_valid_o,
    output logic                 fetch_fault_o
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;
    logic            pend_trap_q, pend_trap_d;

    logic            redir_valid;
    logic            redir_is_trap;
    logic [XLEN-1:0] redir_target;
    logic [XLEN-1:0] final_addr;
    logic            arb_fault;

    logic            req_c;
    logic            we_c;
    logic            ifv_c;
    logic [XLEN-1:0] cand_addr;
    logic            cand_exempt;
    logic            cand_wrap;
    logic [XLEN-1:0] seq_addr;
    logic            seq_carry;
    logic            take_new;
    logic [XLEN-1:0] eff_addr;
    logic            eff_trap;

    pc_redirect_arb #(
        .XLEN      (XLEN),
        .BOOT_ADDR (BOOT_ADDR),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_arb (
        .trap_req_i      (trap_req_i),
        .trap_vec_i      (trap_vec_i),
        .br_taken_i      (br_taken_i),
        .br_target_i     (br_target_i),
        .jmp_valid_i     (jmp_valid_i),
        .jmp_target_i    (jmp_target_i),
        .redir_valid_o   (redir_valid),
        .redir_is_trap_o (redir_is_trap),
        .redir_target_o  (redir_target),
        .cand_addr_i     (cand_addr),
        .cand_exempt_i   (cand_exempt),
        .cand_wrap_i     (cand_wrap),
        .final_addr_o    (final_addr),
        .fault_o         (arb_fault)
    );

    // Next-state and per-cycle strobes; completions and redirects act in
    // the same cycle as the ack so a zero-wait RAM streams one word a cycle.
    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        pend_trap_d = pend_trap_q;
        req_c       = 1'b0;
        we_c        = 1'b0;
        ifv_c       = 1'b0;
        cand_addr   = bus.pc_addr;
        cand_exempt = 1'b0;
        cand_wrap   = 1'b0;
        {seq_carry, seq_addr} = {1'b0, bus.pc_addr} + (XLEN+1)'(INSN_BYTES);
        take_new    = redir_valid && (!pend_trap_q || redir_is_trap);
        eff_addr    = take_new ? redir_target  : pend_addr_q;
        eff_trap    = take_new ? redir_is_trap : pend_trap_q;

        case (state_q)
            ST_INIT: begin
                we_c        = 1'b1;
                cand_addr   = BOOT_ADDR;
                cand_exempt = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_FETCH: begin
                req_c = !stall_i;
                if (redir_valid) begin
                    if (req_c && !bus.imem_ack) begin
                        pend_addr_d = redir_target;
                        pend_trap_d = redir_is_trap;
                        state_d     = ST_DRAIN;
                    end else begin
                        we_c        = 1'b1;
                        cand_addr   = redir_target;
                        cand_exempt = redir_is_trap;
                    end
                end else if (req_c) begin
                    if (bus.imem_ack) begin
                        we_c      = 1'b1;
                        ifv_c     = 1'b1;
                        cand_addr = seq_addr;
                        cand_wrap = seq_carry;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (redir_valid) begin
                    if (bus.imem_ack) begin
                        we_c        = 1'b1;
                        cand_addr   = redir_target;
                        cand_exempt = redir_is_trap;
                        state_d     = ST_FETCH;
                    end else begin
                        pend_addr_d = redir_target;
                        pend_trap_d = redir_is_trap;
                        state_d     = ST_DRAIN;
                    end
                end else if (bus.imem_ack) begin
                    we_c      = 1'b1;
                    ifv_c     = 1'b1;
                    cand_addr = seq_addr;
                    cand_wrap = seq_carry;
                    state_d   = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                req_c = 1'b1;
                if (bus.imem_ack) begin
                    we_c        = 1'b1;
                    cand_addr   = eff_addr;
                    cand_exempt = eff_trap;
                    state_d     = ST_FETCH;
                end else begin
                    pend_addr_d = eff_addr;
                    pend_trap_d = eff_trap;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State and parked redirect; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            pend_addr_q <= '0;
            pend_trap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_trap_q <= pend_trap_d;
        end
    end

    // Outputs are forced quiet while reset is asserted so they drop at once.
    always_comb begin
        bus.imem_req      = rst_n && req_c;
        bus.pc_write_en   = rst_n && we_c;
        if_valid_o        = rst_n && ifv_c;
        fetch_fault_o     = rst_n && we_c && arb_fault;
        bus.imem_addr     = rst_n ? bus.pc_addr : BOOT_ADDR;
        if (!rst_n)
            bus.pc_write_addr = BOOT_ADDR;
        else if (we_c)
            bus.pc_write_addr = final_addr;
        else
            bus.pc_write_addr = bus.pc_addr;
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: models the PC register and a RAM
// with programmable latency, scoreboards every PC write against expected
// {address, if_valid, fetch_fault} triples pushed by the stimulus.
module tb_pc_seq_ctrl;

    localparam int          XLEN = 32;
    localparam logic [31:0] BOOT = 32'h0;

    typedef struct packed {
        logic [31:0] addr;
        logic        ifv;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        trapReq;
    logic [31:0] trapVec;
    logic        brTaken;
    logic [31:0] brTarget;
    logic        jmpValid;
    logic [31:0] jmpTarget;
    logic        ifValid;
    logic        fetchFault;

    logic [31:0] pcReg;
    int          waitCnt;
    int          ramLat;
    int          checks;
    int          failures;
    exp_t        sbQ[$];

    pc_seq_ctrl_if #(.XLEN(XLEN)) bus ();

    pc_seq_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .stall_i       (stall),
        .trap_req_i    (trapReq),
        .trap_vec_i    (trapVec),
        .br_taken_i    (brTaken),
        .br_target_i   (brTarget),
        .jmp_valid_i   (jmpValid),
        .jmp_target_i  (jmpTarget),
        .if_valid_o    (ifValid),
        .fetch_fault_o (fetchFault)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC register, loaded whenever the controller strobes a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pcReg <= BOOT;
        else if (bus.pc_write_en)
            pcReg <= bus.pc_write_addr;
    end
    assign bus.pc_addr = pcReg;

    // RAM model: acks once the request has been held for ramLat cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            waitCnt <= 0;
        else if (bus.imem_req && !bus.imem_ack)
            waitCnt <= waitCnt + 1;
        else
            waitCnt <= 0;
    end
    assign bus.imem_ack = bus.imem_req && (waitCnt >= ramLat);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic tr, input logic [31:0] tv,
                                 input logic br, input logic [31:0] brt,
                                 input logic jv, input logic [31:0] jt);
        stall     = st;
        trapReq   = tr;
        trapVec   = tv;
        brTaken   = br;
        brTarget  = brt;
        jmpValid  = jv;
        jmpTarget = jt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [31:0] a, input logic v, input logic f);
        exp_t e;
        e.addr  = a;
        e.ifv   = v;
        e.fault = f;
        sbQ.push_back(e);
    endtask

    // Scoreboard: every PC write seen at the falling edge must match the
    // oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.pc_write_en) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_write", bus.pc_write_addr, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("wr_addr",  bus.pc_write_addr, e.addr);
                checkOutput("wr_ifv",   {31'b0, ifValid},    {31'b0, e.ifv});
                checkOutput("wr_fault", {31'b0, fetchFault}, {31'b0, e.fault});
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        ramLat   = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset values
        repeat (2) tick();
        #2;
        checkOutput("rst_we",     {31'b0, bus.pc_write_en}, 32'd0);
        checkOutput("rst_req",    {31'b0, bus.imem_req},    32'd0);
        checkOutput("rst_ifv",    {31'b0, ifValid},         32'd0);
        checkOutput("rst_fault",  {31'b0, fetchFault},      32'd0);
        checkOutput("rst_wraddr", bus.pc_write_addr, BOOT);
        checkOutput("rst_iaddr",  bus.imem_addr,     BOOT);

        // Zero-wait RAM streaming
        pushExp(32'h0, 1'b0, 1'b0);
        pushExp(32'h4, 1'b1, 1'b0);
        pushExp(32'h8, 1'b1, 1'b0);
        pushExp(32'hC, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
        #2;
        checkOutput("A_init_we", {31'b0, bus.pc_write_en}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            checkOutput("A_ifv", {31'b0, ifValid},      32'd1);
            checkOutput("A_req", {31'b0, bus.imem_req}, 32'd1);
        end
        tick();
        stall = 1'b1;
        checkOutput("A_sb_empty", sbQ.size(), 32'd0);

        // Stall in FETCH blocks issue; stall during WAIT does not
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            checkOutput("B_stall_req", {31'b0, bus.imem_req},    32'd0);
            checkOutput("B_stall_we",  {31'b0, bus.pc_write_en}, 32'd0);
        end
        tick();
        ramLat = 2;
        stall  = 1'b0;
        pushExp(32'h10, 1'b1, 1'b0);
        #2;
        checkOutput("B_issue_req", {31'b0, bus.imem_req}, 32'd1);
        tick();
        stall = 1'b1;
        #2;
        checkOutput("B_wait_req",  {31'b0, bus.imem_req}, 32'd1);
        checkOutput("B_wait_addr", bus.imem_addr, 32'hC);
        tick();
        #2;
        checkOutput("B_ack_ifv", {31'b0, ifValid}, 32'd1);
        tick();
        #2;
        checkOutput("B_idle_req", {31'b0, bus.imem_req}, 32'd0);
        checkOutput("B_sb_empty", sbQ.size(), 32'd0);

        // Branch in first WAIT cycle parks in DRAIN
        tick();
        stall = 1'b0;
        pushExp(32'h40, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h100, 1'b1, 32'h40, 1'b0, 32'h0);
        #2;
        checkOutput("C_wait_we", {31'b0, bus.pc_write_en}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        checkOutput("C_drain_ifv", {31'b0, ifValid},      32'd0);
        checkOutput("C_drain_req", {31'b0, bus.imem_req}, 32'd1);
        tick();
        stall = 1'b1;
        #2;
        checkOutput("C_next_addr", bus.imem_addr, 32'h40);
        checkOutput("C_sb_empty", sbQ.size(), 32'd0);

        // Trap beats jump; later branch cannot overwrite the parked trap
        tick();
        pushExp(32'h100, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h20);
        #2;
        checkOutput("D_issue_we", {31'b0, bus.pc_write_en}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        #2;
        checkOutput("D_drain_we", {31'b0, bus.pc_write_en}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        stall = 1'b1;
        #2;
        checkOutput("D_next_addr", bus.imem_addr, 32'h100);
        checkOutput("D_sb_empty", sbQ.size(), 32'd0);

        // Illegal targets fault to trap_vec; boundary sequential fault
        tick();
        pushExp(32'h300, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h300, 1'b0, 32'h0, 1'b1, 32'h1002);
        #2;
        checkOutput("E_mis_fault", {31'b0, fetchFault}, 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        checkOutput("E_pulse_fault", {31'b0, fetchFault}, 32'd0);
        tick();
        pushExp(32'h300, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h300, 1'b0, 32'h0, 1'b1, 32'h2000);
        #2;
        checkOutput("E_oor_fault", {31'b0, fetchFault}, 32'd1);
        tick();
        pushExp(32'hFFC, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h300, 1'b0, 32'h0, 1'b1, 32'hFFC);
        #2;
        checkOutput("E_edge_fault", {31'b0, fetchFault}, 32'd0);
        tick();
        ramLat = 0;
        pushExp(32'h300, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        checkOutput("E_seq_fault", {31'b0, fetchFault}, 32'd1);
        tick();
        stall = 1'b1;
        #2;
        checkOutput("E_quiet_fault", {31'b0, fetchFault}, 32'd0);
        tick();
        pushExp(32'h20, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h300, 1'b0, 32'h0, 1'b1, 32'h20);
        #2;
        checkOutput("E_coinc_ifv", {31'b0, ifValid}, 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("E_sb_empty", sbQ.size(), 32'd0);

        // Reset during WAIT drops the request immediately
        tick();
        ramLat = 2;
        stall  = 1'b0;
        tick();
        #1;
        checkOutput("F_wait_req", {31'b0, bus.imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("F_rst_req",    {31'b0, bus.imem_req},    32'd0);
        checkOutput("F_rst_we",     {31'b0, bus.pc_write_en}, 32'd0);
        checkOutput("F_rst_wraddr", bus.pc_write_addr, BOOT);
        stall = 1'b1;
        repeat (2) tick();
        pushExp(32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #2;
        checkOutput("F_init_addr", bus.pc_write_addr, 32'h0);
        tick();
        #2;
        checkOutput("F_idle_req", {31'b0, bus.imem_req}, 32'd0);
        checkOutput("F_sb_empty", sbQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
